// File: rtl/sha_pkg.sv
// sha_pkg: definitions shared by the SHA-256 rotate/shift datapath blocks.
//   WORD_W  - native SHA-256 word width.
//   state_t - FSM encoding for the iterative rotator (ST_IDLE/ST_RUN/ST_DONE).
//   rol_k   - rotate a WORD_W-bit word left by k (k = 0..WORD_W).
package sha_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // With k = 0 the right shift is by WORD_W and contributes nothing.
  function automatic logic [WORD_W-1:0] rol_k(input logic [WORD_W-1:0] word,
                                              input logic [5:0]        k);
    return (word << k) | (word >> (WORD_W - 32'(k)));
  endfunction

endpackage

// File: rtl/rol_step.sv
// rol_step: combinational single stage of the iterative rotator.
// Ports:
//   word   - operand.
//   k      - bits to move this stage (0..STEP, always < WIDTH).
//   mode   - 0 = cyclic rotate left, 1 = logical shift left with zero fill.
//   result - word rotated/shifted left by k.
module rol_step
  import sha_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic [WIDTH-1:0] word,
  input  logic [AMT_W-1:0] k,
  input  logic             mode,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] rot_s;

  generate
    if (WIDTH == int'(WORD_W)) begin : g_word
      // Native word width: reuse the shared rotate helper.
      always_comb rot_s = rol_k(word, 6'(k));
    end else begin : g_generic
      // Other widths: same formula sized to WIDTH.
      always_comb rot_s = (word << k) | (word >> (WIDTH - 32'(k)));
    end
  endgenerate

  // Pick rotate or zero-fill shift.
  always_comb begin
    if (mode) begin
      result = word << k;
    end else begin
      result = rot_s;
    end
  end

endmodule

// File: rtl/left_rotate_iter.sv
// left_rotate_iter: iterative left rotate / logical left shift, moving at most
// STEP bits per clock, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset.
//   in_valid / in_ready  - request handshake; in_ready is high only in IDLE.
//   in_data, in_amt      - word and shift amount (amount taken modulo WIDTH).
//   in_shift             - 0 = rotate left, 1 = shift left with zero fill.
//   out_valid / out_ready- result handshake; out_valid is high only in DONE.
//   out_data             - result; updated only on entry to DONE.
//   busy                 - high in RUN or DONE.
module left_rotate_iter
  import sha_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned WIDTH_U = WIDTH;
  localparam int unsigned STEP_U  = STEP;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic [AMT_W-1:0] amt_mod_s;
  logic [AMT_W-1:0] k_s;
  logic [WIDTH-1:0] step_s;

  // Reduce the requested amount modulo WIDTH (done in 32 bits so that
  // WIDTH == 2**AMT_W does not wrap to a zero divisor).
  always_comb amt_mod_s = AMT_W'(32'(in_amt) % WIDTH_U);

  // Bits to move this cycle: min(STEP, remaining). The STEP branch is only
  // taken when STEP < remaining, so the narrowing cast cannot overflow.
  always_comb begin
    if (32'(rem_q) > STEP_U) begin
      k_s = AMT_W'(STEP_U);
    end else begin
      k_s = rem_q;
    end
  end

  rol_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_rol_step (
    .word   (data_q),
    .k      (k_s),
    .mode   (mode_q),
    .result (step_s)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          rem_d  = amt_mod_s;
          mode_d = in_shift;
          if (amt_mod_s == {AMT_W{1'b0}}) begin
            state_d    = ST_DONE;
            out_data_d = in_data;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        data_d = step_s;
        rem_d  = rem_q - k_s;
        if (rem_q == k_s) begin
          state_d    = ST_DONE;
          out_data_d = step_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= {WIDTH{1'b0}};
      out_data_q <= {WIDTH{1'b0}};
      rem_q      <= {AMT_W{1'b0}};
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
    end
  end

  // Outputs decoded directly from registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

endmodule
